// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S pixel stream transmitter and the mask stage.
// Holds the FSM encoding, default timing constants and counter widths.
package i2s_pkg;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Default timing constants, also consumed by the downstream mask stage
  localparam int I2S_CLK_DIV     = 2;
  localparam int I2S_FRAME_WORDS = 96;
  localparam int I2S_GAP_CYCLES  = 16;

  // Counter widths; the parameter ranges are chosen so these never wrap
  localparam int BYTE_W     = 8;
  localparam int WORD_CNT_W = 12;
  localparam int HALF_CNT_W = 8;
  localparam int BIT_CNT_W  = 3;

  // Terminal count for a counter that runs 0..n-1
  function automatic logic [WORD_CNT_W-1:0] last_index(input int n);
    return WORD_CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/i2s_bit_timer.sv
// Half-period timer for the serial bit clock.
// Counts CLK_DIV clk cycles per half period and toggles the i2s_clk phase flop
// at the end of each half. While disabled or restarted, the phase is held low
// so the bit clock parks glitch-free at 0.
module i2s_bit_timer
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick,
  output logic phase
);

  localparam logic [HALF_CNT_W-1:0] LAST_HALF = HALF_CNT_W'(CLK_DIV - 1);

  logic [HALF_CNT_W-1:0] half_cnt;

  assign tick = en && !restart && (half_cnt == LAST_HALF);

  // Half-period counter and phase flop; the phase flop is the bit clock itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      phase    <= 1'b0;
    end else if (restart || !en) begin
      half_cnt <= '0;
      phase    <= 1'b0;
    end else if (half_cnt == LAST_HALF) begin
      half_cnt <= '0;
      phase    <= ~phase;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_stream_tx.sv
// Byte-stream to I2S-style serialiser for the LED mask chain.
// Bytes enter through a one-entry holding register, are shifted out MSB first
// under a gated bit clock, grouped into frames of FRAME_WORDS bytes framed by
// i2s_ws, and separated by GAP_CYCLES idle cycles.
module i2s_stream_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV     = I2S_CLK_DIV,
  parameter int FRAME_WORDS = I2S_FRAME_WORDS,
  parameter int GAP_CYCLES  = I2S_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              i2s_clk,
  output logic              i2s_data,
  output logic              i2s_ws,
  output logic              frame_done,
  output logic              underrun
);

  localparam logic [WORD_CNT_W-1:0] LAST_WORD = last_index(FRAME_WORDS);
  localparam logic [WORD_CNT_W-1:0] LAST_GAP  = last_index(GAP_CYCLES);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BYTE_W - 1);

  state_t                state;
  logic                  ready_en;
  logic                  hold_full;
  logic [BYTE_W-1:0]     hold_data;
  logic [BYTE_W-1:0]     shift_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic [WORD_CNT_W-1:0] gap_cnt;

  logic tick;
  logic phase;
  logic timer_en;
  logic timer_restart;
  logic accept;
  logic bit_end;
  logic byte_end;
  logic gap_last;
  logic load;

  // ready_en keeps in_ready low until the first edge after reset releases
  assign in_ready = ready_en & ~hold_full;
  assign accept   = in_valid & in_ready;

  // A bit finishes when the high half of the bit clock expires
  assign bit_end  = (state == SHIFT) && tick && phase;
  assign byte_end = bit_end && (bit_cnt == LAST_BIT);
  assign gap_last = (state == GAP) && (gap_cnt == LAST_GAP);

  // Every path that moves the held byte into the shift register
  assign load = hold_full && ((state == IDLE) || (state == STALL) || gap_last ||
                              (byte_end && (word_cnt != LAST_WORD)));

  assign timer_en      = (state == SHIFT);
  assign timer_restart = load && (state != SHIFT);

  i2s_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (timer_en),
    .restart (timer_restart),
    .tick    (tick),
    .phase   (phase)
  );

  assign i2s_clk = phase;

  // Holding register: a simultaneous accept and load refills with the new byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en  <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Frame FSM with shift register, counters and registered serial outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      gap_cnt    <= '0;
      i2s_data   <= 1'b0;
      i2s_ws     <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          i2s_data <= 1'b0;
          i2s_ws   <= 1'b0;
          if (hold_full) begin
            state     <= SHIFT;
            i2s_ws    <= 1'b1;
            i2s_data  <= hold_data[BYTE_W-1];
            shift_reg <= {hold_data[BYTE_W-2:0], 1'b0};
            bit_cnt   <= '0;
            word_cnt  <= '0;
            underrun  <= 1'b0;
          end
        end

        SHIFT: begin
          if (bit_end) begin
            if (bit_cnt != LAST_BIT) begin
              i2s_data  <= shift_reg[BYTE_W-1];
              shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
              bit_cnt   <= bit_cnt + 1'b1;
            end else if (word_cnt == LAST_WORD) begin
              state      <= GAP;
              gap_cnt    <= '0;
              frame_done <= 1'b1;
              i2s_ws     <= 1'b0;
              i2s_data   <= 1'b0;
            end else if (hold_full) begin
              i2s_data  <= hold_data[BYTE_W-1];
              shift_reg <= {hold_data[BYTE_W-2:0], 1'b0};
              bit_cnt   <= '0;
              word_cnt  <= word_cnt + 1'b1;
            end else begin
              state    <= STALL;
              underrun <= 1'b1;
            end
          end
        end

        STALL: begin
          underrun <= 1'b1;
          if (hold_full) begin
            state     <= SHIFT;
            i2s_data  <= hold_data[BYTE_W-1];
            shift_reg <= {hold_data[BYTE_W-2:0], 1'b0};
            bit_cnt   <= '0;
            word_cnt  <= word_cnt + 1'b1;
          end
        end

        GAP: begin
          i2s_data <= 1'b0;
          i2s_ws   <= 1'b0;
          if (gap_cnt == LAST_GAP) begin
            gap_cnt <= '0;
            // The last gap cycle doubles as the idle decision cycle, so
            // back-to-back frames are separated by exactly GAP_CYCLES
            if (hold_full) begin
              state     <= SHIFT;
              i2s_ws    <= 1'b1;
              i2s_data  <= hold_data[BYTE_W-1];
              shift_reg <= {hold_data[BYTE_W-2:0], 1'b0};
              bit_cnt   <= '0;
              word_cnt  <= '0;
              underrun  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Self-checking bench for i2s_stream_tx.
// A monitor records each frame as observed on the serial pins; the reference
// expectation is the queue of accepted bytes, MSB first, chunked into frames.
module tb_i2s_stream_tx;

  localparam int A_DIV = 2;
  localparam int A_FW  = 4;
  localparam int A_GAP = 16;
  localparam int B_GAP = 16;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       i2s_clk;
  logic       i2s_data;
  logic       i2s_ws;
  logic       frame_done;
  logic       underrun;

  logic [7:0] in_data_b;
  logic       in_valid_b;
  logic       in_ready_b;
  logic       i2s_clk_b;
  logic       i2s_data_b;
  logic       i2s_ws_b;
  logic       frame_done_b;
  logic       underrun_b;

  int checks;
  int failures;

  logic [7:0] exp_q[$];

  i2s_stream_tx #(
    .CLK_DIV     (A_DIV),
    .FRAME_WORDS (A_FW),
    .GAP_CYCLES  (A_GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .i2s_clk    (i2s_clk),
    .i2s_data   (i2s_data),
    .i2s_ws     (i2s_ws),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  i2s_stream_tx #(
    .CLK_DIV     (1),
    .FRAME_WORDS (1),
    .GAP_CYCLES  (B_GAP)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data_b),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .i2s_clk    (i2s_clk_b),
    .i2s_data   (i2s_data_b),
    .i2s_ws     (i2s_ws_b),
    .frame_done (frame_done_b),
    .underrun   (underrun_b)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Frame monitor for the main instance, sampled on the falling edge
  int         cyc;
  logic       prev_sclk;
  logic       prev_ws;
  int         cur_rises;
  int         cur_ws;
  int         cur_high;
  int         cur_first;
  int         cur_last;
  int         cur_gap;
  int         low_run;
  logic       cur_start_ur;
  logic [31:0] cur_word;
  int         frames_done;
  logic [31:0] rec_word[16];
  int         rec_rises[16];
  int         rec_ws[16];
  int         rec_high[16];
  int         rec_span[16];
  int         rec_gap[16];
  logic       rec_start_ur[16];
  logic       rec_end_ur[16];

  initial begin
    cyc = 0;
    frames_done = 0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      prev_sclk    = 1'b0;
      prev_ws      = 1'b0;
      cur_rises    = 0;
      cur_ws       = 0;
      cur_high     = 0;
      cur_first    = 0;
      cur_last     = 0;
      cur_gap      = 0;
      low_run      = 0;
      cur_start_ur = 1'b0;
      cur_word     = '0;
    end else begin
      if (i2s_ws && !prev_ws) begin
        cur_gap      = low_run;
        cur_start_ur = underrun;
      end
      if (i2s_ws) begin
        cur_ws  = cur_ws + 1;
        low_run = 0;
      end else begin
        low_run = low_run + 1;
      end
      if (i2s_clk) cur_high = cur_high + 1;
      if (i2s_clk && !prev_sclk) begin
        cur_word = {cur_word[30:0], i2s_data};
        if (cur_rises == 0) cur_first = cyc;
        cur_last  = cyc;
        cur_rises = cur_rises + 1;
      end
      if (frame_done) begin
        if (frames_done < 16) begin
          rec_word[frames_done]     = cur_word;
          rec_rises[frames_done]    = cur_rises;
          rec_ws[frames_done]       = cur_ws;
          rec_high[frames_done]     = cur_high;
          rec_span[frames_done]     = cur_last - cur_first;
          rec_gap[frames_done]      = cur_gap;
          rec_start_ur[frames_done] = cur_start_ur;
          rec_end_ur[frames_done]   = underrun;
        end
        frames_done = frames_done + 1;
        cur_rises = 0;
        cur_ws    = 0;
        cur_high  = 0;
        cur_word  = '0;
      end
      prev_sclk = i2s_clk;
      prev_ws   = i2s_ws;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Offer one byte to the main instance and wait (bounded) for its acceptance
  task automatic applyStimulus(input logic [7:0] b);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    while (!ok && t < 400) begin
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
      #1;
      t = t + 1;
    end
    in_valid = 1'b0;
    checkOutput("accept", 32'(ok), 32'd1);
    if (ok) exp_q.push_back(b);
  endtask

  // First byte of a frame from idle: ws and MSB appear two cycles after it is offered
  task automatic startFrame(input logic [7:0] b);
    applyStimulus(b);
    checkOutput("lat_ws_early", 32'(i2s_ws), 32'd0);
    checkOutput("lat_hold_full", 32'(in_ready), 32'd0);
    step(1);
    checkOutput("lat_ws", 32'(i2s_ws), 32'd1);
    checkOutput("lat_msb", 32'(i2s_data), 32'(b[7]));
  endtask

  task automatic waitFrames(input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 2000) begin
      step(1);
      t = t + 1;
    end
    checkOutput("frame_wait", 32'(frames_done >= target), 32'd1);
  endtask

  // Compare a recorded frame against the next FRAME_WORDS accepted bytes
  task automatic checkFrame(input int idx);
    logic [31:0] exp_word;
    exp_word = '0;
    for (int i = 0; i < A_FW; i++) begin
      if (exp_q.size() > 0) exp_word = {exp_word[23:0], exp_q.pop_front()};
    end
    checkOutput($sformatf("f%0d_bits", idx), rec_word[idx], exp_word);
    checkOutput($sformatf("f%0d_nbits", idx), 32'(rec_rises[idx]), 32'(A_FW * 8));
  endtask

  initial begin
    int          t;
    int          bad;
    int          fd;
    int          hi;
    int          chg;
    int          wsl;
    int          saved_frames;
    logic        held;
    logic        prev_b;
    int          rises_b;
    int          first_b;
    int          last_b;
    int          fd_cyc_b;
    int          data_hi_b;
    int          ws_b;
    int          cyc_b;
    logic [7:0]  word_b;
    logic [31:0] fixed_word;

    checks     = 0;
    failures   = 0;
    in_data    = '0;
    in_valid   = 1'b0;
    in_data_b  = '0;
    in_valid_b = 1'b0;

    // Reset state and in_ready release timing
    rst = 1'b1;
    step(3);
    checkOutput("reset_outs", {26'd0, in_ready, i2s_clk, i2s_data, i2s_ws, frame_done, underrun}, 32'd0);
    checkOutput("reset_outs_b", {26'd0, in_ready_b, i2s_clk_b, i2s_data_b, i2s_ws_b, frame_done_b, underrun_b}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_release", 32'(in_ready), 32'd0);
    step(1);
    checkOutput("ready_first_edge", 32'(in_ready), 32'd1);
    step(2);

    // Frame 0: fixed bytes back-to-back
    startFrame(8'hA5);
    applyStimulus(8'h3C);
    applyStimulus(8'hFF);
    applyStimulus(8'h00);
    waitFrames(1);
    fixed_word = rec_word[0];
    checkOutput("f0_fixed", fixed_word, 32'hA53CFF00);
    checkFrame(0);
    checkOutput("f0_ws_cycles", 32'(rec_ws[0]), 32'(A_FW * 8 * 2 * A_DIV));
    checkOutput("f0_span", 32'(rec_span[0]), 32'((A_FW * 8 - 1) * 2 * A_DIV));
    checkOutput("f0_high", 32'(rec_high[0]), 32'(A_FW * 8 * A_DIV));
    bad = 0;
    fd  = 0;
    for (int i = 0; i < A_GAP; i++) begin
      if (i > 0) step(1);
      if (i2s_ws || i2s_clk || i2s_data || !in_ready) bad = bad + 1;
      fd = fd + int'(frame_done);
    end
    checkOutput("f0_gap_idle", 32'(bad), 32'd0);
    checkOutput("f0_done_pulses", 32'(fd), 32'd1);
    step(3);

    // Frame 1 with a mid-frame stall, followed directly by frame 2
    startFrame(8'($urandom));
    applyStimulus(8'($urandom));
    t = 0;
    while (!underrun && t < 200) begin
      step(1);
      t = t + 1;
    end
    checkOutput("stall_underrun", 32'(underrun), 32'd1);
    held = i2s_data;
    hi   = 0;
    chg  = 0;
    wsl  = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      hi  = hi + int'(i2s_clk);
      chg = chg + int'(i2s_data != held);
      wsl = wsl + int'(!i2s_ws);
    end
    checkOutput("stall_clk_low", 32'(hi), 32'd0);
    checkOutput("stall_data_hold", 32'(chg), 32'd0);
    checkOutput("stall_ws_hold", 32'(wsl), 32'd0);
    checkOutput("stall_sticky", 32'(underrun), 32'd1);
    applyStimulus(8'($urandom));
    applyStimulus(8'($urandom));
    for (int i = 0; i < A_FW; i++) applyStimulus(8'($urandom));
    waitFrames(3);
    checkFrame(1);
    checkFrame(2);
    checkOutput("f1_end_underrun", 32'(rec_end_ur[1]), 32'd1);
    checkOutput("f2_start_underrun", 32'(rec_start_ur[2]), 32'd0);
    checkOutput("f2_gap", 32'(rec_gap[2]), 32'(A_GAP));

    // Frames 3 and 4 streamed continuously
    for (int i = 0; i < 2 * A_FW; i++) applyStimulus(8'($urandom));
    waitFrames(5);
    checkFrame(3);
    checkFrame(4);
    checkOutput("f4_gap", 32'(rec_gap[4]), 32'(A_GAP));
    checkOutput("f4_ws_cycles", 32'(rec_ws[4]), 32'(A_FW * 8 * 2 * A_DIV));
    checkOutput("f4_start_underrun", 32'(rec_start_ur[4]), 32'd0);
    step(A_GAP + 4);

    // Reset in the middle of a frame
    saved_frames = frames_done;
    startFrame(8'($urandom));
    applyStimulus(8'($urandom));
    applyStimulus(8'($urandom));
    t = 0;
    while (cur_rises < 13 && t < 200) begin
      step(1);
      t = t + 1;
    end
    checkOutput("reach_bit13", 32'(cur_rises >= 13), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outs", {26'd0, in_ready, i2s_clk, i2s_data, i2s_ws, frame_done, underrun}, 32'd0);
    step(3);
    rst = 1'b0;
    exp_q.delete();
    step(2);
    checkOutput("no_done_on_reset", 32'(frames_done), 32'(saved_frames));
    checkOutput("post_reset_idle", {29'd0, i2s_ws, i2s_clk, in_ready}, 32'd1);
    startFrame(8'($urandom));
    for (int i = 1; i < A_FW; i++) applyStimulus(8'($urandom));
    waitFrames(saved_frames + 1);
    checkFrame(saved_frames);

    // Single-byte frames at the fastest bit clock
    step(2);
    in_data_b  = 8'h80;
    in_valid_b = 1'b1;
    step(1);
    in_valid_b = 1'b0;
    prev_b    = 1'b0;
    rises_b   = 0;
    first_b   = 0;
    last_b    = 0;
    fd_cyc_b  = -1;
    data_hi_b = 0;
    word_b    = '0;
    cyc_b     = 0;
    while (fd_cyc_b < 0 && cyc_b < 200) begin
      step(1);
      cyc_b = cyc_b + 1;
      if (i2s_clk_b && !prev_b) begin
        word_b = {word_b[6:0], i2s_data_b};
        if (rises_b == 0) first_b = cyc_b;
        last_b  = cyc_b;
        rises_b = rises_b + 1;
      end
      if (i2s_data_b) data_hi_b = data_hi_b + 1;
      if (frame_done_b) fd_cyc_b = cyc_b;
      prev_b = i2s_clk_b;
    end
    checkOutput("b_rises", 32'(rises_b), 32'd8);
    checkOutput("b_bits", 32'(word_b), 32'h80);
    checkOutput("b_span", 32'(last_b - first_b), 32'd14);
    checkOutput("b_data_high", 32'(data_hi_b), 32'd2);
    checkOutput("b_done_timing", 32'(fd_cyc_b), 32'(last_b + 1));
    bad  = 0;
    ws_b = 0;
    for (int i = 0; i < B_GAP; i++) begin
      if (!in_ready_b) bad = bad + 1;
      ws_b = ws_b + int'(i2s_ws_b);
      step(1);
    end
    checkOutput("b_gap_ready", 32'(bad), 32'd0);
    checkOutput("b_gap_ws", 32'(ws_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_stream_tx.md
I2S_STREAM_TX -- requirements
Module: i2s_stream_tx

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- CLK_DIV, 2: clk cycles per i2s_clk half-period; legal range 1..255.
- FRAME_WORDS, 96: bytes per frame; legal range 1..4095.
- GAP_CYCLES, 16: idle clk cycles after each frame; legal range 1..4095.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  pixel byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a byte.
- i2s_clk  out  1  gated serial bit clock to the downstream mask/LED stage.
- i2s_data  out  1  serial data, MSB first, stable across the i2s_clk rising edge.
- i2s_ws  out  1  frame active; high from the first bit to the last bit of a frame.
- frame_done  out  1  one-cycle pulse after the last bit of a frame.
- underrun  out  1  sticky flag: input ran dry mid-frame.

Function
REQ-003 The block SHALL contain a 1-entry holding register.
- in_ready = ~hold_full.
- A byte is accepted when in_valid && in_ready.
- hold_full SHALL clear in the cycle the byte moves to the shift register.
REQ-004 The FSM SHALL have exactly the states IDLE, SHIFT, STALL and GAP, encoded in the package.
REQ-005 IDLE: i2s_clk=0, i2s_data=0, i2s_ws=0; go to SHIFT on the cycle hold_full=1, loading the shift register and clearing word_cnt.
REQ-006 Latency: a byte accepted at cycle N in IDLE SHALL produce i2s_ws=1 with its MSB on i2s_data at cycle N+2.
REQ-007 SHIFT, per bit:
- i2s_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
- i2s_data changes only at the start of the low phase.
- i2s_clk SHALL be glitch-free and driven from a flop.
REQ-008 After bit 0 of a byte, the next transition SHALL be taken in the following priority order:
- word_cnt==FRAME_WORDS-1: go to GAP and pulse frame_done.
- Otherwise, if hold_full: load the next byte with no extra clocks (back-to-back bits).
- Otherwise: go to STALL.
REQ-009 STALL:
- i2s_clk=0; i2s_data and i2s_ws hold their values.
- underrun is set.
- Return to SHIFT with the new MSB on the cycle after hold_full=1.
REQ-010 GAP: i2s_clk=0, i2s_data=0, i2s_ws=0 for exactly GAP_CYCLES cycles, then go to IDLE; in_ready keeps operating normally.
REQ-011 underrun SHALL clear only on rst or on entry to SHIFT from IDLE, i.e. at the start of a frame.
REQ-012 word_cnt is 12 bits and the half-period counter is 8 bits; neither SHALL wrap within a frame.
REQ-013 If in_valid and a shift-register load coincide, the accept and the load SHALL both occur in that cycle; no byte is lost or duplicated.

Reset
REQ-014 While rst=1, the block SHALL hold: state=IDLE, hold_full=0, in_ready=0, i2s_clk=0, i2s_data=0, i2s_ws=0, frame_done=0, underrun=0, all counters 0.
REQ-015 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-016 A reset mid-frame SHALL abort the frame immediately with no frame_done; partial bytes are discarded.

Structure
REQ-017 Package i2s_pkg SHALL hold the FSM state encoding and the default parameter constants (CLK_DIV, FRAME_WORDS, GAP_CYCLES) shared with the mask stage.
REQ-018 Sub-module i2s_bit_timer SHALL generate the half-period tick and i2s_clk phase, with enable and restart inputs.
REQ-019 The FSM, holding register and shift register SHALL reside in i2s_stream_tx.

Verification (CLK_DIV=2, FRAME_WORDS=4, GAP_CYCLES=16 unless noted)
REQ-020 Bytes A5,3C,FF,00 presented back-to-back:
- 32 contiguous i2s_clk pulses, period 4 clk.
- Bits sampled on rising edges = A53CFF00.
- i2s_ws high for 128 cycles, then one frame_done pulse and 16 idle cycles.
REQ-021 Same frame, in_valid dropped for 20 cycles after byte 2:
- i2s_clk stops low and underrun=1.
- Output resumes with byte 3 MSB; the total bit stream is unchanged.
REQ-022 rst asserted at bit 13 of a frame:
- All outputs reach their reset values asynchronously; no frame_done.
- The next frame after release starts cleanly with ws and MSB at N+2.
REQ-023 Two frames streamed continuously:
- Exactly a 16-cycle gap with i2s_ws=0 between them.
- underrun cleared at the second frame start.
REQ-024 CLK_DIV=1, FRAME_WORDS=1, byte 80:
- i2s_clk period 2 clk; i2s_data high only for bit 7.
- frame_done on the cycle after the 8th rising-edge bit ends.
- in_ready stays asserted throughout the gap.
